rlc_mul: RTL and testbench



---
 rtl/rlc_pkg.sv | 26 ++
 rtl/rlc_step.sv | 45 ++++
 rtl/rlc_mul.sv | 112 +++++++++++
 tb/tb_rlc_mul.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rlc_pkg.sv
// Shared types and helpers for the rotation-mode linear CORDIC multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, step-constant helper, counter-width helper.
package rlc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rlc_state_t;

  // Step constant for iteration k: 1.0 (1<<quan) shifted right by k.
  // The value is always positive, so a logical shift equals the arithmetic one.
  // Returned wide; callers size-cast it to their data width.
  function automatic logic [63:0] step_const(input int quan, input int k);
    return (64'd1 << quan) >> k;
  endfunction

  // Iteration counter width: $clog2(iter), never less than one bit.
  function automatic int cnt_w(input int iter);
    return (iter <= 1) ? 1 : $clog2(iter);
  endfunction

endpackage

// File: rtl/rlc_step.sv
// One linear-CORDIC rotation-mode micro-rotation (drives z toward zero, accumulates x*z into y).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   x, y, z : current multiplicand, accumulator and residual (signed two's complement)
//   k       : iteration index selecting the shift amount
//   y_next  : y +/- (x >>> k)
//   z_next  : z -/+ (1.0 >>> k)
module rlc_step
  import rlc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CORDIC_QUAN = 16,
  parameter int KW          = 4
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] y,
  input  logic signed [DATA_WIDTH-1:0] z,
  input  logic        [KW-1:0]         k,
  output logic signed [DATA_WIDTH-1:0] y_next,
  output logic signed [DATA_WIDTH-1:0] z_next
);

  logic signed [DATA_WIDTH-1:0] x_shift;
  logic signed [DATA_WIDTH-1:0] step;
  logic                         z_neg;

  assign x_shift = x >>> k;
  assign step    = DATA_WIDTH'(step_const(CORDIC_QUAN, int'(k)));
  // z == 0 counts as non-negative and still takes a step; the residual then
  // oscillates around zero and the final error stays within one LSB step.
  assign z_neg   = z[DATA_WIDTH-1];

  always_comb begin
    if (z_neg) begin
      y_next = y - x_shift;
      z_next = z + step;
    end else begin
      y_next = y + x_shift;
      z_next = z - step;
    end
  end

endmodule

// File: rtl/rlc_mul.sv
// Iterative shift/add multiplier: y_out = y_in + x_in*z_in, one micro-rotation per clock.
// Latency: accept at cycle t, out_valid at t+ITER+1; one result per ITER+1 cycles back-to-back.
// Backpressure: valid/ready; result held stable in DONE until out_ready, in_ready low while busy.
//
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   in_valid/in_ready     : operand handshake for x_in, y_in, z_in
//   out_valid/out_ready   : result handshake for y_out, z_out
//   y_out                 : accumulated product
//   z_out                 : residual (close to zero when z_in is in range)
module rlc_mul
  import rlc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CORDIC_QUAN = 16,
  parameter int ITER        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [DATA_WIDTH-1:0] z_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic [DATA_WIDTH-1:0] z_out
);

  localparam int            KW     = cnt_w(ITER);
  localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);

  rlc_state_t state, state_next;

  logic        [KW-1:0]         k;
  logic signed [DATA_WIDTH-1:0] x_r, y_r, z_r;
  logic signed [DATA_WIDTH-1:0] y_next, z_next;
  logic                         load, step_en;

  rlc_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .CORDIC_QUAN(CORDIC_QUAN),
    .KW         (KW)
  ) u_step (
    .x     (x_r),
    .y     (y_r),
    .z     (z_r),
    .k     (k),
    .y_next(y_next),
    .z_next(z_next)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step_en    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step_en = 1'b1;
        if (k == K_LAST) state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          // Consume and accept in the same cycle to keep back-to-back throughput.
          if (in_valid) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        x_r <= x_in;
        y_r <= y_in;
        z_r <= z_in;
        k   <= '0;
      end else if (step_en) begin
        y_r <= y_next;
        z_r <= z_next;
        k   <= k + KW'(1);
      end
    end
  end

  // Ready is held low during reset so nothing is handed over that reset would drop.
  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign y_out     = y_r;
  assign z_out     = z_r;

endmodule

// File: tb/tb_rlc_mul.sv
// Directed self-checking bench for rlc_mul (Q16, ITER=16).
// Latency: n/a.
// Backpressure: exercises consumer stall and back-to-back accept.
module tb_rlc_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in, y_in, z_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_out, z_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rlc_mul #(
    .DATA_WIDTH (32),
    .CORDIC_QUAN(16),
    .ITER       (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y_out    (y_out),
    .z_out    (z_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; lat counts cycles since the accepting edge.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // Present operands (caller sets out_ready), accept, then check result and latency.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input logic [31:0] ey, input logic [31:0] ez);
    int lat;
    x_in     = x;
    y_in     = y;
    z_in     = z;
    in_valid = 1'b1;
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_result(lat);
    check_val({tag, "_lat"}, 32'(lat), 32'd17);
    check_val({tag, "_y"}, y_out, ey);
    check_val({tag, "_z"}, z_out, ez);
  endtask

  initial begin
    int lat;
    logic [31:0] y_hold, z_hold;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    tick();
    tick();
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_y_out", y_out, 32'h0);
    check_val("rst_z_out", z_out, 32'h0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_val("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed products, consumer always ready.
    run_op("mul_2x0p5",   32'h0002_0000, 32'h0, 32'h0000_8000, 32'h0001_0004, 32'hFFFF_FFFE);
    tick();
    check_val("consumed_out_valid", 32'(out_valid), 32'd0);
    run_op("mul_m2x0p5",  32'hFFFE_0000, 32'h0, 32'h0000_8000, 32'hFFFE_FFFC, 32'hFFFF_FFFE);
    tick();
    run_op("mul_1x0",     32'h0001_0000, 32'h0, 32'h0000_0000, 32'h0000_0002, 32'hFFFF_FFFE);
    tick();
    run_op("mac_2x0p5p1", 32'h0002_0000, 32'h0001_0000, 32'h0000_8000, 32'h0002_0004, 32'hFFFF_FFFE);
    tick();
    run_op("mul_2xm0p5",  32'h0002_0000, 32'h0, 32'hFFFF_8000, 32'hFFFF_0004, 32'hFFFF_FFFE);
    tick();

    // Consumer stall: result must hold, no new operands taken.
    out_ready = 1'b0;
    run_op("bp", 32'h0002_0000, 32'h0, 32'h0000_8000, 32'h0001_0004, 32'hFFFF_FFFE);
    y_hold   = y_out;
    z_hold   = z_out;
    in_valid = 1'b1;
    x_in     = 32'h0003_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
      check_val("bp_y_hold", y_out, y_hold);
      check_val("bp_z_hold", z_out, z_hold);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_val("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back: in_valid held, second operand taken as the first result is consumed.
    x_in     = 32'h0002_0000;
    y_in     = 32'h0;
    z_in     = 32'h0000_8000;
    in_valid = 1'b1;
    tick();
    x_in = 32'h0001_0000;
    y_in = 32'h0;
    z_in = 32'h0000_0000;
    wait_result(lat);
    check_val("b2b_a_lat", 32'(lat), 32'd17);
    check_val("b2b_a_y", y_out, 32'h0001_0004);
    check_val("b2b_a_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("b2b_b_running", 32'(out_valid), 32'd0);
    wait_result(lat);
    check_val("b2b_b_lat", 32'(lat), 32'd17);
    check_val("b2b_b_y", y_out, 32'h0000_0002);
    check_val("b2b_b_z", z_out, 32'hFFFF_FFFE);
    tick();

    // Reset while iterating drops the operation.
    x_in     = 32'h0002_0000;
    y_in     = 32'h0;
    z_in     = 32'h0000_8000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    #1;
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_y_out", y_out, 32'h0);
    check_val("mid_rst_z_out", z_out, 32'h0);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("post_rst_idle", 32'(out_valid), 32'd0);
    run_op("post_rst", 32'h0002_0000, 32'h0001_0000, 32'h0000_8000, 32'h0002_0004, 32'hFFFF_FFFE);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
